btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 111 +++++++++++
 tb/tb_btn_debounce.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Per-channel push-button debouncer: a 2-flop synchronizer feeding a 4-state
// confirm/hold FSM with a saturating stability counter, producing registered level and press strobe.
module btn_debounce #(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    CHK_PRESS,
    PRESSED,
    CHK_RELEASE
  } stateT;

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic [N_BTN-1:0] syncMeta;
  logic [N_BTN-1:0] syncOut;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      syncMeta <= '0;
      syncOut  <= '0;
    end else begin
      syncMeta <= i_btn;
      syncOut  <= syncMeta;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : gChan
    stateT                state;
    stateT                stateNext;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cntNext;
    logic                 levelQ;
    logic                 levelNext;
    logic                 pulseQ;
    logic                 pulseNext;

    always_comb begin
      stateNext = state;
      cntNext   = cnt;
      levelNext = levelQ;
      pulseNext = 1'b0;
      case (state)
        IDLE: begin
          if (syncOut[g]) begin
            stateNext = CHK_PRESS;
            cntNext   = '0;
          end
        end
        CHK_PRESS: begin
          if (!syncOut[g]) begin
            stateNext = IDLE;
            cntNext   = '0;
          end else if (cnt == LAST) begin
            stateNext = PRESSED;
            levelNext = 1'b1;
            pulseNext = 1'b1;
          end else begin
            cntNext = cnt + ONE;
          end
        end
        PRESSED: begin
          if (!syncOut[g]) begin
            stateNext = CHK_RELEASE;
            cntNext   = '0;
          end
        end
        CHK_RELEASE: begin
          // A bounce back high simply resumes the held state; level never dropped.
          if (syncOut[g]) begin
            stateNext = PRESSED;
          end else if (cnt == LAST) begin
            stateNext = IDLE;
            levelNext = 1'b0;
          end else begin
            cntNext = cnt + ONE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        state  <= IDLE;
        cnt    <= '0;
        levelQ <= 1'b0;
        pulseQ <= 1'b0;
      end else begin
        state  <= stateNext;
        cnt    <= cntNext;
        levelQ <= levelNext;
        pulseQ <= pulseNext;
      end
    end

    assign o_level[g] = levelQ;
    assign o_pulse[g] = pulseQ;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: vector table, directed corner sequences,
// and randomized bouncing inputs checked against a sliding-window reference model.
module tb_btn_debounce;

  localparam int D = 4;
  localparam int H = D + 3;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [2:0] i_btn;
  logic [2:0] o_level;
  logic [2:0] o_pulse;

  int nChecks = 0;
  int nFail   = 0;

  btn_debounce #(
    .N_BTN(3),
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH(3)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_btn(i_btn),
    .o_level(o_level),
    .o_pulse(o_pulse)
  );

  always #5 i_clk = ~i_clk;

  // Reference: the raw sample taken at edge k reaches the channel logic at edge k+2,
  // so the level flips once the D+1 samples taken 2..D+2 edges ago all disagree with it.
  logic [H-1:0] hist [3];
  logic [2:0]   mLevel;
  logic [2:0]   mPulse;

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < 3; c++) hist[c] = '0;
      mLevel = '0;
      mPulse = '0;
    end else begin
      mPulse = '0;
      for (int c = 0; c < 3; c++) begin
        hist[c] = {hist[c][H-2:0], i_btn[c]};
        if (!mLevel[c] && (&hist[c][D+2:2])) begin
          mLevel[c] = 1'b1;
          mPulse[c] = 1'b1;
        end else if (mLevel[c] && !(|hist[c][D+2:2])) begin
          mLevel[c] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive inputs, let one rising edge pass, return at the next negedge.
  task automatic cyc(input logic [2:0] b);
    i_btn = b;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic doReset(input string name);
    i_reset = 1'b1;
    #1;
    check({name, "_rstLevel"}, 32'(o_level), 32'd0);
    check({name, "_rstPulse"}, 32'(o_pulse), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0] btn;
    logic [2:0] expLevel;
    logic [2:0] expPulse;
  } vecT;

  vecT tbl[17];
  int  pulses;
  int  levelDrops;
  bit  seenPulse;

  initial begin
    for (int i = 0; i < 17; i++) begin
      tbl[i].btn      = (i < 10) ? 3'b001 : 3'b000;
      tbl[i].expPulse = (i == 6) ? 3'b001 : 3'b000;
      tbl[i].expLevel = (i >= 6 && i <= 15) ? 3'b001 : 3'b000;
    end

    i_reset = 1'b1;
    i_btn   = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    doReset("init");

    // Clean press then clean release on channel 0
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].btn);
      check($sformatf("tbl%0d_level", i), 32'(o_level), 32'(tbl[i].expLevel));
      check($sformatf("tbl%0d_pulse", i), 32'(o_pulse), 32'(tbl[i].expPulse));
    end

    // Bounce on channel 1: samples 1,0,1,0 then steady high from edge 5
    doReset("bounce");
    begin
      logic [2:0] pat [4];
      pat[0] = 3'b010; pat[1] = 3'b000; pat[2] = 3'b010; pat[3] = 3'b000;
      for (int e = 1; e <= 16; e++) begin
        cyc(e <= 4 ? pat[e-1] : 3'b010);
        check($sformatf("bounce_pulse_e%0d", e), 32'(o_pulse), (e == 11) ? 32'd2 : 32'd0);
      end
      check("bounce_level", 32'(o_level), 32'd2);
    end

    // Release glitch on channel 2
    doReset("glitch");
    for (int e = 1; e <= 8; e++) cyc(3'b100);
    check("glitch_setLevel", 32'(o_level), 32'd4);
    cyc(3'b000);
    cyc(3'b000);
    for (int e = 1; e <= 10; e++) begin
      cyc(3'b100);
      check($sformatf("glitch_hold_e%0d", e), 32'({o_level, o_pulse}), 32'({3'b100, 3'b000}));
    end
    for (int e = 1; e <= 10; e++) begin
      cyc(3'b000);
      check($sformatf("glitch_rel_e%0d", e), 32'(o_level), (e >= 7) ? 32'd0 : 32'd4);
    end

    // Simultaneous press on all channels
    doReset("simul");
    for (int e = 1; e <= 9; e++) begin
      cyc(3'b111);
      check($sformatf("simul_pulse_e%0d", e), 32'(o_pulse), (e == 7) ? 32'd7 : 32'd0);
    end

    // Reset during a held press, then a full re-debounce
    doReset("midA");
    for (int e = 1; e <= 4; e++) begin
      cyc(3'b001);
      check($sformatf("mid_pre_e%0d", e), 32'(o_pulse), 32'd0);
    end
    doReset("midB");
    for (int e = 1; e <= 8; e++) begin
      cyc(3'b001);
      check($sformatf("mid_post_e%0d", e), 32'(o_pulse), (e == 7) ? 32'd1 : 32'd0);
    end

    // Long hold: one pulse, level stays high afterwards
    doReset("long");
    pulses = 0;
    levelDrops = 0;
    seenPulse = 1'b0;
    for (int e = 1; e <= 1000; e++) begin
      cyc(3'b001);
      if (o_pulse[0]) begin
        pulses++;
        seenPulse = 1'b1;
      end else if (seenPulse && !o_level[0]) begin
        levelDrops++;
      end
    end
    check("long_pulses", 32'(pulses), 32'd1);
    check("long_levelDrops", 32'(levelDrops), 32'd0);

    // Randomized bouncing inputs with occasional resets against the model
    for (int k = 0; k < 4000; k++) begin
      @(negedge i_clk);
      check("rand_level", 32'(o_level), 32'(mLevel));
      check("rand_pulse", 32'(o_pulse), 32'(mPulse));
      if (i_reset) i_reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) i_reset = 1'b1;
      for (int c = 0; c < 3; c++)
        if ($urandom_range(0, 5) == 0) i_btn[c] = ~i_btn[c];
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
